// File: rtl/accel_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : accel_pkg
// Brief    : Shared types and defaults for the accelerator unit memory interface.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package accel_pkg;

   localparam int c_NUM_UNITS  = 4;
   localparam int c_DATA_W     = 16;
   localparam int c_VEC_LEN    = 16;
   localparam int c_NUM_VEC    = 16;
   localparam int c_ACCESS_LAT = 1;
   localparam int c_VW         = c_VEC_LEN * c_DATA_W;

   typedef enum logic [3:0] {
      OP_VEC_READ       = 4'b0001,
      OP_VEC_WRITE      = 4'b0010,
      OP_COMP           = 4'b0100,
      OP_MAT_ROW_READ   = 4'b1000,
      OP_MAT_ELEM_WRITE = 4'b1001
   } mem_op_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_ACCESS  = 2'd2,
      ST_RESPOND = 2'd3
   } mem_state_t;

   function automatic logic is_read_op(input logic [3:0] op);
      return (op == OP_VEC_READ) || (op == OP_MAT_ROW_READ);
   endfunction

   function automatic logic is_write_op(input logic [3:0] op);
      return (op == OP_VEC_WRITE) || (op == OP_MAT_ELEM_WRITE);
   endfunction

   function automatic logic is_legal_op(input logic [3:0] op);
      return is_read_op(op) || is_write_op(op) || (op == OP_COMP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; search starts after last_served.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_last_served,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   int               w_cand;
   logic [IDX_W-1:0] w_cand_idx;

   always_comb begin
      o_grant    = '0;
      o_idx      = '0;
      o_valid    = 1'b0;
      w_cand     = 0;
      w_cand_idx = '0;
      for (int k = 1; k <= N; k++) begin
         w_cand     = (int'(i_last_served) + k) % N;
         w_cand_idx = IDX_W'(w_cand);
         if (!o_valid && i_req[w_cand_idx]) begin
            o_grant[w_cand_idx] = 1'b1;
            o_idx               = w_cand_idx;
            o_valid             = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_responder
// Brief    : Arbitrated responder serving vector/matrix accesses from an internal
//            store. Define MEM_PERF_CNT_EN to add rd_count/wr_count outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_responder
   import accel_pkg::*;
#(
   parameter int NUM_UNITS  = c_NUM_UNITS,
   parameter int DATA_W     = c_DATA_W,
   parameter int VEC_LEN    = c_VEC_LEN,
   parameter int NUM_VEC    = c_NUM_VEC,
   parameter int ACCESS_LAT = c_ACCESS_LAT
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic [NUM_UNITS-1:0]                mem_request,
   input  logic [4*NUM_UNITS-1:0]              mem_op_type,
   input  logic [4*NUM_UNITS-1:0]              vec_index,
   input  logic [4*NUM_UNITS-1:0]              mat_row,
   input  logic [4*NUM_UNITS-1:0]              mat_col,
   input  logic [VEC_LEN*DATA_W*NUM_UNITS-1:0] write_data,
   output logic [NUM_UNITS-1:0]                mem_grant,
   output logic [NUM_UNITS-1:0]                mem_done,
   output logic [VEC_LEN*DATA_W-1:0]           read_data,
   output logic                                mem_err,
   output logic                                busy
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [31:0]                         rd_count,
   output logic [31:0]                         wr_count
`endif
);

   localparam int c_VW    = VEC_LEN * DATA_W;
   localparam int c_IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   typedef logic [VEC_LEN-1:0][DATA_W-1:0] row_t;

   logic [3:0]      w_op    [NUM_UNITS];
   logic [3:0]      w_vidx  [NUM_UNITS];
   logic [3:0]      w_row   [NUM_UNITS];
   logic [3:0]      w_col   [NUM_UNITS];
   logic [c_VW-1:0] w_wdata [NUM_UNITS];

   generate
      for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unpack
         assign w_op[u]    = mem_op_type[u*4 +: 4];
         assign w_vidx[u]  = vec_index[u*4 +: 4];
         assign w_row[u]   = mat_row[u*4 +: 4];
         assign w_col[u]   = mat_col[u*4 +: 4];
         assign w_wdata[u] = write_data[u*c_VW +: c_VW];
      end
   endgenerate

   mem_state_t         r_state, w_next_state;
   logic [c_IDX_W-1:0] r_last_served, r_winner, w_arb_idx;
   logic [NUM_UNITS-1:0] r_winner_oh, w_arb_grant;
   logic               w_arb_valid;
   logic [3:0]         r_op, r_vec_idx, r_row, r_col;
   logic [c_VW-1:0]    r_wdata, r_read_data, w_rd_data;
   logic               r_err;
   logic [2:0]         r_lat_cnt;
   logic               w_lat_last, w_commit;

   // Storage is deliberately not reset.
   row_t r_vec [NUM_VEC];
   row_t r_mat [VEC_LEN];

   rr_arbiter #(.N(NUM_UNITS), .IDX_W(c_IDX_W)) u_arb (
      .i_req         (mem_request),
      .i_last_served (r_last_served),
      .o_grant       (w_arb_grant),
      .o_idx         (w_arb_idx),
      .o_valid       (w_arb_valid)
   );

   assign w_lat_last = (r_lat_cnt == 3'(ACCESS_LAT - 1));
   assign w_commit   = (r_state == ST_ACCESS) && !flush && w_lat_last;
   assign read_data  = r_read_data;

   always_comb begin
      w_rd_data = '0;
      if (r_op == OP_VEC_READ)          w_rd_data = r_vec[r_vec_idx];
      else if (r_op == OP_MAT_ROW_READ) w_rd_data = r_mat[r_row];
   end

   always_comb begin
      w_next_state = r_state;
      mem_grant    = '0;
      mem_done     = '0;
      mem_err      = 1'b0;
      busy         = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE:    if (w_arb_valid) w_next_state = ST_GRANT;
         ST_GRANT: begin
            mem_grant    = r_winner_oh;
            w_next_state = flush ? ST_IDLE : ST_ACCESS;
         end
         ST_ACCESS: begin
            if (flush)           w_next_state = ST_IDLE;
            else if (w_lat_last) w_next_state = ST_RESPOND;
         end
         ST_RESPOND: begin
            mem_done     = r_winner_oh;
            mem_err      = r_err;
            w_next_state = ST_IDLE;
         end
         default:    w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_last_served <= c_IDX_W'(NUM_UNITS - 1);
         r_winner      <= '0;
         r_winner_oh   <= '0;
         r_op          <= '0;
         r_vec_idx     <= '0;
         r_row         <= '0;
         r_col         <= '0;
         r_wdata       <= '0;
         r_err         <= 1'b0;
         r_lat_cnt     <= '0;
         r_read_data   <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            ST_IDLE: if (w_arb_valid) begin
               r_winner    <= w_arb_idx;
               r_winner_oh <= w_arb_grant;
               r_op        <= w_op[w_arb_idx];
               r_vec_idx   <= w_vidx[w_arb_idx];
               r_row       <= w_row[w_arb_idx];
               r_col       <= w_col[w_arb_idx];
               r_wdata     <= w_wdata[w_arb_idx];
               r_err       <= !is_legal_op(w_op[w_arb_idx]);
            end
            ST_GRANT:   r_lat_cnt <= '0;
            ST_ACCESS: if (!flush) begin
               r_lat_cnt <= r_lat_cnt + 3'd1;
               if (w_lat_last) r_read_data <= w_rd_data;
            end
            ST_RESPOND: r_last_served <= r_winner;
            default:    ;
         endcase
      end
   end

   // A reset landing on the commit edge drops the pending write.
   always_ff @(posedge clk) begin
      if (!rst && w_commit) begin
         if (r_op == OP_VEC_WRITE)           r_vec[r_vec_idx] <= r_wdata;
         else if (r_op == OP_MAT_ELEM_WRITE) r_mat[r_row][r_col] <= r_wdata[DATA_W-1:0];
      end
   end

`ifdef MEM_PERF_CNT_EN
   logic [31:0] r_rd_count, r_wr_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else if (r_state == ST_RESPOND) begin
         if (is_read_op(r_op) && (r_rd_count != 32'hFFFF_FFFF))  r_rd_count <= r_rd_count + 32'd1;
         if (is_write_op(r_op) && (r_wr_count != 32'hFFFF_FFFF)) r_wr_count <= r_wr_count + 32'd1;
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mem_responder
// Brief    : Directed self-checking bench for mem_responder (MEM_PERF_CNT_EN aware).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mem_responder;

   localparam int NU  = 4;
   localparam int VW  = 256;
   localparam int LAT = 1;

   logic              clk = 1'b0;
   logic              rst, flush;
   logic [NU-1:0]     mem_request;
   logic [4*NU-1:0]   mem_op_type, vec_index, mat_row, mat_col;
   logic [VW*NU-1:0]  write_data;
   logic [NU-1:0]     mem_grant, mem_done;
   logic [VW-1:0]     read_data;
   logic              mem_err, busy;
`ifdef MEM_PERF_CNT_EN
   logic [31:0]       rd_count, wr_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [VW-1:0] pat_a5, pat_09, pat_66;

   mem_responder dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .mem_request (mem_request),
      .mem_op_type (mem_op_type),
      .vec_index   (vec_index),
      .mat_row     (mat_row),
      .mat_col     (mat_col),
      .write_data  (write_data),
      .mem_grant   (mem_grant),
      .mem_done    (mem_done),
      .read_data   (read_data),
      .mem_err     (mem_err),
      .busy        (busy)
`ifdef MEM_PERF_CNT_EN
      ,
      .rd_count    (rd_count),
      .wr_count    (wr_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int u, input logic [3:0] op, input logic [3:0] vi,
                          input logic [3:0] row, input logic [3:0] col, input logic [VW-1:0] wd);
      mem_op_type[u*4 +: 4] = op;
      vec_index[u*4 +: 4]   = vi;
      mat_row[u*4 +: 4]     = row;
      mat_col[u*4 +: 4]     = col;
      write_data[u*VW +: VW] = wd;
      mem_request[u]        = 1'b1;
   endtask

   task automatic wait_grant(input int u, input int exp_wait);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (mem_grant == '0 && n < 20);
      if (exp_wait > 0) check("grant_wait", VW'(n), VW'(exp_wait));
      check("grant", VW'(mem_grant), VW'(1 << u));
      check("busy_grant", VW'(busy), VW'(1));
   endtask

   task automatic serve(input int u, input int exp_wait, input logic exp_err,
                        input logic chk_rd, input logic [VW-1:0] exp_rd);
      wait_grant(u, exp_wait);
      repeat (LAT) begin
         @(negedge clk);
         check("done_early", VW'(mem_done), '0);
      end
      @(negedge clk);
      check("done", VW'(mem_done), VW'(1 << u));
      check("err", VW'(mem_err), VW'(exp_err));
      if (chk_rd) check("rdata", read_data, exp_rd);
      mem_request[u] = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      pat_a5 = {16{16'hA5A5}};
      pat_09 = {16{16'h0909}};
      pat_66 = {16{16'h6666}};
      flush = 1'b0; mem_request = '0; mem_op_type = '0; vec_index = '0;
      mat_row = '0; mat_col = '0; write_data = '0;
      do_reset();
      check("rst_grant", VW'(mem_grant), '0);
      check("rst_done", VW'(mem_done), '0);
      check("rst_err", VW'(mem_err), '0);
      check("rst_busy", VW'(busy), '0);
      check("rst_rdata", read_data, '0);

      // Write then read back vector 5 from unit 2
      set_req(2, 4'b0010, 4'd5, 4'd0, 4'd0, pat_a5);
      serve(2, 1, 1'b0, 1'b0, '0);
      set_req(2, 4'b0001, 4'd5, 4'd0, 4'd0, '0);
      serve(2, 2, 1'b0, 1'b1, pat_a5);
      @(negedge clk);
      check("idle_busy", VW'(busy), '0);
      check("idle_done", VW'(mem_done), '0);
      check("rdata_hold", read_data, pat_a5);

      // Four simultaneous requests, then a burst from units 1 and 3
      do_reset();
      for (int u = 0; u < NU; u++) set_req(u, 4'b0001, 4'(u), 4'd0, 4'd0, '0);
      serve(0, 1, 1'b0, 1'b0, '0);
      serve(1, 2, 1'b0, 1'b0, '0);
      serve(2, 2, 1'b0, 1'b0, '0);
      serve(3, 2, 1'b0, 1'b0, '0);
      set_req(1, 4'b0001, 4'd1, 4'd0, 4'd0, '0);
      set_req(3, 4'b0001, 4'd3, 4'd0, 4'd0, '0);
      serve(1, 2, 1'b0, 1'b0, '0);
      serve(3, 2, 1'b0, 1'b0, '0);

      // Matrix element write and row read, including the far corner
      set_req(0, 4'b1001, 4'd0, 4'd3, 4'd7, 256'h1234);
      serve(0, 0, 1'b0, 1'b0, '0);
      set_req(1, 4'b1001, 4'd0, 4'd15, 4'd15, 256'hBEEF);
      serve(1, 0, 1'b0, 1'b0, '0);
      set_req(0, 4'b1000, 4'd0, 4'd3, 4'd0, '0);
      serve(0, 0, 1'b0, 1'b0, '0);
      check("mat_r3c7", VW'(read_data[7*16 +: 16]), VW'(16'h1234));
      set_req(1, 4'b1000, 4'd0, 4'd15, 4'd0, '0);
      serve(1, 0, 1'b0, 1'b0, '0);
      check("mat_r15c15", VW'(read_data[15*16 +: 16]), VW'(16'hBEEF));

      // Illegal op: error flagged, zero data, storage untouched
      set_req(1, 4'b0011, 4'd5, 4'd3, 4'd7, '1);
      serve(1, 0, 1'b1, 1'b1, '0);
      set_req(2, 4'b0001, 4'd5, 4'd0, 4'd0, '0);
      serve(2, 0, 1'b0, 1'b1, pat_a5);
      set_req(3, 4'b1000, 4'd0, 4'd3, 4'd0, '0);
      serve(3, 0, 1'b0, 1'b0, '0);
      check("ill_mat_keep", VW'(read_data[7*16 +: 16]), VW'(16'h1234));
      set_req(2, 4'b0100, 4'd0, 4'd0, 4'd0, '1);
      serve(2, 0, 1'b0, 1'b1, '0);

      // Flush during ACCESS abandons the write to vector 9
      set_req(0, 4'b0010, 4'd9, 4'd0, 4'd0, pat_09);
      serve(0, 0, 1'b0, 1'b0, '0);
      set_req(0, 4'b0010, 4'd9, 4'd0, 4'd0, '1);
      wait_grant(0, 0);
      @(negedge clk);
      flush = 1'b1;
      mem_request[0] = 1'b0;
      check("flush_access_done", VW'(mem_done), '0);
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle_busy", VW'(busy), '0);
      check("flush_idle_done", VW'(mem_done), '0);
      @(negedge clk);
      check("flush_no_done", VW'(mem_done), '0);
      set_req(0, 4'b0001, 4'd9, 4'd0, 4'd0, '0);
      serve(0, 0, 1'b0, 1'b1, pat_09);

      // Reset during GRANT drops the pending write and restarts arbitration
      set_req(3, 4'b0010, 4'd9, 4'd0, 4'd0, pat_66);
      wait_grant(3, 0);
      rst = 1'b1;
      mem_request[3] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("rstg_grant", VW'(mem_grant), '0);
      check("rstg_done", VW'(mem_done), '0);
      check("rstg_err", VW'(mem_err), '0);
      check("rstg_busy", VW'(busy), '0);
      check("rstg_rdata", read_data, '0);
`ifdef MEM_PERF_CNT_EN
      check("rstg_rd_count", VW'(rd_count), '0);
      check("rstg_wr_count", VW'(wr_count), '0);
`endif
      set_req(1, 4'b0001, 4'd9, 4'd0, 4'd0, '0);
      set_req(0, 4'b0001, 4'd9, 4'd0, 4'd0, '0);
      serve(0, 1, 1'b0, 1'b1, pat_09);
      @(negedge clk);
`ifdef MEM_PERF_CNT_EN
      check("rd_count_1", VW'(rd_count), VW'(1));
      check("wr_count_0", VW'(wr_count), '0);
`endif
      serve(1, 1, 1'b0, 1'b1, pat_09);
      set_req(2, 4'b0010, 4'd10, 4'd0, 4'd0, pat_66);
      serve(2, 0, 1'b0, 1'b0, '0);
      @(negedge clk);
`ifdef MEM_PERF_CNT_EN
      check("rd_count_2", VW'(rd_count), VW'(2));
      check("wr_count_1", VW'(wr_count), VW'(1));
`endif
      check("end_busy", VW'(busy), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
